// File: rtl/restoring_divider_seq.sv
// rtl/restoring_divider_seq.sv - multi-cycle restoring divider, signed/unsigned, divide-by-zero flag
module restoring_divider_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  // dvd_q starts as the dividend magnitude and fills with quotient bits from the LSB
  logic [N-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N-1:0]  dvd_raw_q, dvd_raw_d;
  logic [N:0]    r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q_q, neg_q_d;
  logic          neg_r_q, neg_r_d;
  logic          dz_q, dz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic          div_by_zero_q, div_by_zero_d;

  logic [N-1:0]  dvd_mag;
  logic [N-1:0]  dvs_mag;
  logic [N+1:0]  diff;

  // Next-state and datapath: operand capture, one quotient bit per RUN cycle, sign fix-up in FIX
  always_comb begin
    state_d       = state_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    dvd_raw_d     = dvd_raw_q;
    r_d           = r_q;
    cnt_d         = cnt_q;
    neg_q_d       = neg_q_q;
    neg_r_d       = neg_r_q;
    dz_d          = dz_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    dvd_mag = (signed_mode && dividend[N-1]) ? -dividend : dividend;
    dvs_mag = (signed_mode && divisor[N-1])  ? -divisor  : divisor;
    // Trial subtraction of the shifted partial remainder; bit N+1 is the borrow/sign
    diff    = {r_q, dvd_q[N-1]} - {2'b00, dvs_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_raw_d = dividend;
          dvd_d     = dvd_mag;
          dvs_d     = dvs_mag;
          r_d       = '0;
          cnt_d     = CW'(N);
          neg_q_d   = signed_mode & (dividend[N-1] ^ divisor[N-1]);
          neg_r_d   = signed_mode & dividend[N-1];
          busy_d    = 1'b1;
          if (divisor == '0) begin
            dz_d    = 1'b1;
            state_d = FIX;
          end else begin
            dz_d    = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!diff[N+1]) begin
          r_d = diff[N:0];
        end else begin
          r_d = {r_q[N-1:0], dvd_q[N-1]};
        end
        dvd_d = {dvd_q[N-2:0], ~diff[N+1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (dz_q) begin
          quotient_d    = '1;
          remainder_d   = dvd_raw_q;
          div_by_zero_d = 1'b1;
        end else begin
          quotient_d    = neg_q_q ? -dvd_q : dvd_q;
          remainder_d   = neg_r_q ? -r_q[N-1:0] : r_q[N-1:0];
          div_by_zero_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; async reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dvd_q         <= '0;
      dvs_q         <= '0;
      dvd_raw_q     <= '0;
      r_q           <= '0;
      cnt_q         <= '0;
      neg_q_q       <= 1'b0;
      neg_r_q       <= 1'b0;
      dz_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dvd_q         <= dvd_d;
      dvs_q         <= dvs_d;
      dvd_raw_q     <= dvd_raw_d;
      r_q           <= r_d;
      cnt_q         <= cnt_d;
      neg_q_q       <= neg_q_d;
      neg_r_q       <= neg_r_d;
      dz_q          <= dz_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_restoring_divider_seq.sv
// tb/tb_restoring_divider_seq.sv - directed-vector bench for restoring_divider_seq
module tb_restoring_divider_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       signed_mode;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int total;
  int bad;

  restoring_divider_seq #(.N(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wait up to a bounded number of edges for done; returns the edge count, 0 on timeout
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_div(input string tag, input logic sm, input logic [7:0] a,
                         input logic [7:0] b, input int exp_lat, input logic [7:0] eq,
                         input logic [7:0] er, input logic ez);
    int lat;
    @(negedge clk);
    start       = 1'b1;
    signed_mode = sm;
    dividend    = a;
    divisor     = b;
    @(posedge clk);
    #1;
    check({tag, ".busy_after_start"}, busy, 1);
    start       = 1'b0;
    signed_mode = ~sm;
    dividend    = 8'h55;
    divisor     = 8'h33;
    wait_done(lat);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".busy_in_done"}, busy, 0);
    check({tag, ".quotient"}, quotient, eq);
    check({tag, ".remainder"}, remainder, er);
    check({tag, ".dbz"}, div_by_zero, ez);
    @(posedge clk);
    #1;
    check({tag, ".done_one_cycle"}, done, 0);
    check({tag, ".quotient_held"}, quotient, eq);
  endtask

  initial begin
    int lat;
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    dividend    = 8'h00;
    divisor     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.quotient", quotient, 0);
    check("reset.remainder", remainder, 0);
    check("reset.dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div("u10_2",   1'b0, 8'd10,  8'd2,  9, 8'd5,  8'd0,  1'b0);
    run_div("u200_7",  1'b0, 8'd200, 8'd7,  9, 8'd28, 8'd4,  1'b0);
    run_div("s-7_2",   1'b1, 8'hF9,  8'h02, 9, 8'hFD, 8'hFF, 1'b0);
    run_div("s7_-2",   1'b1, 8'h07,  8'hFE, 9, 8'hFD, 8'h01, 1'b0);
    run_div("s_ovf",   1'b1, 8'h80,  8'hFF, 9, 8'h80, 8'h00, 1'b0);
    run_div("u255_16", 1'b0, 8'hFF,  8'h10, 9, 8'h0F, 8'h0F, 1'b0);
    run_div("dbz",     1'b0, 8'h2A,  8'h00, 1, 8'hFF, 8'h2A, 1'b1);
    run_div("after_dbz", 1'b0, 8'd9, 8'd3,  9, 8'd3,  8'd0,  1'b0);

    // start held high through the operation with operands changed mid-flight
    @(negedge clk);
    start       = 1'b1;
    signed_mode = 1'b0;
    dividend    = 8'd100;
    divisor     = 8'd9;
    @(posedge clk);
    #1;
    check("hold.busy", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    dividend = 8'd50;
    divisor  = 8'd3;
    check("hold.still_busy", busy, 1);
    wait_done(lat);
    check("hold.latency", lat, 6);
    check("hold.quotient", quotient, 8'd11);
    check("hold.remainder", remainder, 8'd1);
    check("hold.busy_in_done", busy, 0);
    // start still high in the done cycle: 50/3 is accepted at this edge
    @(posedge clk);
    #1;
    check("b2b.busy", busy, 1);
    check("b2b.done_low", done, 0);
    start = 1'b0;
    wait_done(lat);
    check("b2b.latency", lat, 9);
    check("b2b.quotient", quotient, 8'd16);
    check("b2b.remainder", remainder, 8'd2);

    // reset during RUN
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.quotient", quotient, 0);
    check("rst.remainder", remainder, 0);
    check("rst.dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(lat);
    check("rst.no_done", lat, 0);
    run_div("u15_4", 1'b0, 8'd15, 8'd4, 9, 8'd3, 8'd3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
